avalon_stream_mailbox: RTL and testbench



---
 rtl/avalon_stream_mailbox_pkg.sv | 23 ++
 rtl/avalon_stream_mailbox_sync_fifo.sv | 66 ++++++
 rtl/avalon_stream_mailbox.sv | 135 +++++++++++++
 tb/tb_avalon_stream_mailbox.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_stream_mailbox_pkg.sv
// Register map and field positions shared by the mailbox top level and its bench.
package mailbox_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_THRESH  = 2'd3;

    localparam int ST_TX_CNT   = 0;
    localparam int ST_RX_CNT   = 8;
    localparam int ST_TX_FULL  = 16;
    localparam int ST_TX_EMPTY = 17;
    localparam int ST_RX_FULL  = 18;
    localparam int ST_RX_EMPTY = 19;
    localparam int ST_TX_OVF   = 20;
    localparam int ST_RX_UNF   = 21;
    localparam int ST_IRQ      = 22;

    localparam int CT_TX_FLUSH = 0;
    localparam int CT_RX_FLUSH = 1;
    localparam int CT_IRQ_EN   = 2;

endpackage

// File: rtl/avalon_stream_mailbox_sync_fifo.sv
// Single-clock first-word fall-through FIFO; flush wins over push and pop.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) count_d = count_q + CW'(1);
            if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/avalon_stream_mailbox.sv
// Avalon-MM mailbox: CPU writes feed the TX stream, RX stream feeds CPU reads,
// with status, sticky error flags and an RX-occupancy interrupt.
module avalon_stream_mailbox
    import mailbox_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CW     = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              AVL_CS,
    input  logic [1:0]        AVL_ADDR,
    input  logic              AVL_READ,
    input  logic              AVL_WRITE,
    input  logic [DATA_W-1:0] AVL_WRITEDATA,
    output logic [DATA_W-1:0] AVL_READDATA,
    output logic              IRQ,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY
);

    logic              wr, rd;
    logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] rx_dout, status;
    logic              irq_pending;
    logic              unused_wdata;

    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              tx_ovf_q, tx_ovf_d;
    logic              rx_unf_q, rx_unf_d;
    logic              irq_en_q, irq_en_d;
    logic [CW-1:0]     thresh_q, thresh_d;
    logic              irq_q;

    assign wr = AVL_CS && AVL_WRITE;
    assign rd = AVL_CS && AVL_READ;

    assign tx_push  = wr && (AVL_ADDR == ADDR_DATA);
    assign tx_pop   = TX_VALID && TX_READY;
    assign tx_flush = wr && (AVL_ADDR == ADDR_CONTROL) && AVL_WRITEDATA[CT_TX_FLUSH];
    assign rx_push  = RX_VALID && RX_READY;
    assign rx_pop   = rd && (AVL_ADDR == ADDR_DATA);
    assign rx_flush = wr && (AVL_ADDR == ADDR_CONTROL) && AVL_WRITEDATA[CT_RX_FLUSH];

    assign unused_wdata = ^AVL_WRITEDATA;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(CLK), .rst(RESET), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(AVL_WRITEDATA), .dout(TX_DATA), .count(tx_count),
        .full(tx_full), .empty(tx_empty)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(CLK), .rst(RESET), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
        .din(RX_DATA), .dout(rx_dout), .count(rx_count),
        .full(rx_full), .empty(rx_empty)
    );

    assign TX_VALID    = !tx_empty;
    assign RX_READY    = !rx_full;
    assign irq_pending = irq_en_q && (thresh_q != '0) && (rx_count >= thresh_q);

    always_comb begin
        status = '0;
        status[ST_TX_CNT +: 8] = 8'(tx_count);
        status[ST_RX_CNT +: 8] = 8'(rx_count);
        status[ST_TX_FULL]     = tx_full;
        status[ST_TX_EMPTY]    = tx_empty;
        status[ST_RX_FULL]     = rx_full;
        status[ST_RX_EMPTY]    = rx_empty;
        status[ST_TX_OVF]      = tx_ovf_q;
        status[ST_RX_UNF]      = rx_unf_q;
        status[ST_IRQ]         = irq_pending;
    end

    always_comb begin
        readdata_d = readdata_q;
        if (rd) begin
            case (AVL_ADDR)
                ADDR_DATA:    readdata_d = rx_empty ? '0 : rx_dout;
                ADDR_STATUS:  readdata_d = status;
                ADDR_CONTROL: begin
                    readdata_d            = '0;
                    readdata_d[CT_IRQ_EN] = irq_en_q;
                end
                default:      readdata_d = DATA_W'(thresh_q);
            endcase
        end
    end

    // An error in the same cycle as its W1C clear wins, so no event is lost.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_unf_d = rx_unf_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        if (wr && (AVL_ADDR == ADDR_STATUS)) begin
            if (AVL_WRITEDATA[ST_TX_OVF]) tx_ovf_d = 1'b0;
            if (AVL_WRITEDATA[ST_RX_UNF]) rx_unf_d = 1'b0;
        end
        if (wr && (AVL_ADDR == ADDR_CONTROL)) irq_en_d = AVL_WRITEDATA[CT_IRQ_EN];
        if (wr && (AVL_ADDR == ADDR_THRESH))  thresh_d = AVL_WRITEDATA[CW-1:0];
        if (tx_push && tx_full)  tx_ovf_d = 1'b1;
        if (rx_pop && rx_empty)  rx_unf_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            readdata_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            thresh_q   <= CW'(1);
            irq_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_unf_q   <= rx_unf_d;
            irq_en_q   <= irq_en_d;
            thresh_q   <= thresh_d;
            irq_q      <= irq_pending;
        end
    end

    assign AVL_READDATA = readdata_q;
    assign IRQ          = irq_q;

endmodule

// File: tb/tb_avalon_stream_mailbox.sv
// Scoreboard bench for avalon_stream_mailbox (DATA_W=32, DEPTH=16).
module tb_avalon_stream_mailbox;
    import mailbox_pkg::*;

    localparam int DW = 32;
    localparam int DP = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          AVL_CS = 1'b0, AVL_READ = 1'b0, AVL_WRITE = 1'b0;
    logic [1:0]    AVL_ADDR = '0;
    logic [DW-1:0] AVL_WRITEDATA = '0, AVL_READDATA;
    logic          IRQ;
    logic [DW-1:0] TX_DATA;
    logic          TX_VALID;
    logic          TX_READY = 1'b0;
    logic [DW-1:0] RX_DATA = '0;
    logic          RX_VALID = 1'b0;
    logic          RX_READY;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    logic          m_ovf = 1'b0, m_unf = 1'b0, m_irq_en = 1'b0;
    logic [4:0]    m_thresh = 5'd1;
    logic [DW-1:0] rdata;

    avalon_stream_mailbox #(.DATA_W(DW), .DEPTH(DP)) dut (
        .CLK(CLK), .RESET(RESET), .AVL_CS(AVL_CS), .AVL_ADDR(AVL_ADDR),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .IRQ(IRQ), .TX_DATA(TX_DATA),
        .TX_VALID(TX_VALID), .TX_READY(TX_READY), .RX_DATA(RX_DATA),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_status();
        logic [DW-1:0] s;
        int tc, rc;
        tc = tx_q.size();
        rc = rx_q.size();
        s = '0;
        s[7:0]  = 8'(tc);
        s[15:8] = 8'(rc);
        s[16] = (tc == DP);
        s[17] = (tc == 0);
        s[18] = (rc == DP);
        s[19] = (rc == 0);
        s[20] = m_ovf;
        s[21] = m_unf;
        s[22] = m_irq_en && (m_thresh != 0) && (rc >= int'(m_thresh));
        return s;
    endfunction

    // TX scoreboard: every accepted stream beat must match the oldest CPU write.
    always @(negedge CLK) begin
        if (!RESET && TX_VALID && TX_READY) begin
            if (tx_q.size() == 0) check_val("tx_extra", {31'b0, TX_VALID}, '0);
            else check_val("tx_data", TX_DATA, tx_q.pop_front());
        end
    end

    task automatic avl_write(input logic [1:0] a, input logic [DW-1:0] d);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = a; AVL_WRITEDATA = d;
        case (a)
            ADDR_DATA:    if (tx_q.size() < DP) tx_q.push_back(d); else m_ovf = 1'b1;
            ADDR_STATUS:  begin if (d[20]) m_ovf = 1'b0; if (d[21]) m_unf = 1'b0; end
            ADDR_CONTROL: begin
                if (d[0]) tx_q.delete();
                if (d[1]) rx_q.delete();
                m_irq_en = d[2];
            end
            default:      m_thresh = d[4:0];
        endcase
        tick();
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    // Expected value is computed from the model at issue time, then compared.
    task automatic avl_read_chk(input string tag, input logic [1:0] a);
        logic [DW-1:0] exp;
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = a;
        case (a)
            ADDR_DATA: begin
                if (rx_q.size() > 0) exp = rx_q.pop_front();
                else begin exp = '0; m_unf = 1'b1; end
            end
            ADDR_STATUS:  exp = exp_status();
            ADDR_CONTROL: exp = {29'b0, m_irq_en, 2'b00};
            default:      exp = {27'b0, m_thresh};
        endcase
        tick();
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        rdata = AVL_READDATA;
        check_val(tag, rdata, exp);
    endtask

    task automatic rx_push(input logic [DW-1:0] d);
        RX_VALID = 1'b1; RX_DATA = d;
        check_val("rx_ready", {31'b0, RX_READY}, {31'b0, rx_q.size() < DP});
        if (rx_q.size() < DP) rx_q.push_back(d);
        tick();
        RX_VALID = 1'b0;
    endtask

    task automatic drain_tx(input string tag);
        TX_READY = 1'b1;
        for (int i = 0; i < 80 && tx_q.size() > 0; i++) tick();
        check_val(tag, tx_q.size(), 0);
        tick();
        TX_READY = 1'b0;
        check_val({tag, "_valid"}, {31'b0, TX_VALID}, '0);
    endtask

    initial begin
        repeat (3) tick();
        RESET = 1'b0;
        tick();
        check_val("rst_irq", {31'b0, IRQ}, '0);
        check_val("rst_rx_ready", {31'b0, RX_READY}, 32'd1);
        check_val("rst_tx_valid", {31'b0, TX_VALID}, '0);
        check_val("rst_readdata", AVL_READDATA, '0);
        avl_read_chk("rst_status", ADDR_STATUS);
        check_val("rst_status_const", rdata, 32'h000A0000);

        // TX overflow with the sink stalled
        for (int i = 0; i < 17; i++) avl_write(ADDR_DATA, 32'h100 + i);
        avl_read_chk("tx_full_status", ADDR_STATUS);
        check_val("tx_full_fields", rdata & 32'h001100FF, 32'h00110010);
        check_val("tx_head", TX_DATA, 32'h100);
        drain_tx("tx_drain1");
        avl_write(ADDR_STATUS, 32'h00100000);
        avl_read_chk("ovf_clear", ADDR_STATUS);

        // RX threshold interrupt
        avl_write(ADDR_THRESH, 32'd3);
        avl_write(ADDR_CONTROL, 32'd4);
        avl_read_chk("ctrl_read", ADDR_CONTROL);
        rx_push(32'hA1); rx_push(32'hA2); rx_push(32'hA3);
        check_val("irq_lat1", {31'b0, IRQ}, '0);
        tick();
        check_val("irq_rise", {31'b0, IRQ}, 32'd1);
        avl_read_chk("rx_pop1", ADDR_DATA);
        check_val("irq_hold", {31'b0, IRQ}, 32'd1);
        avl_read_chk("rx_pop2", ADDR_DATA);
        check_val("irq_fall", {31'b0, IRQ}, '0);
        avl_read_chk("rx_pop3", ADDR_DATA);

        // Underflow
        avl_read_chk("rx_unf_data", ADDR_DATA);
        avl_read_chk("rx_unf_status", ADDR_STATUS);
        avl_write(ADDR_STATUS, 32'h00200000);
        avl_read_chk("unf_clear", ADDR_STATUS);

        // Full TX with same-cycle CPU push and stream pop
        for (int i = 0; i < DP; i++) avl_write(ADDR_DATA, 32'h200 + i);
        TX_READY = 1'b1;
        avl_write(ADDR_DATA, 32'h2FF);
        TX_READY = 1'b0;
        avl_read_chk("push_pop_full", ADDR_STATUS);
        check_val("push_pop_cnt", rdata & 32'h001000FF, 32'h0010000F);
        avl_write(ADDR_STATUS, 32'h00100000);

        // Wrap-around with random sink back-pressure
        for (int i = 0; i < 40; i++) begin
            TX_READY = 1'($urandom_range(0, 1));
            avl_write(ADDR_DATA, 32'h1000 + i);
        end
        drain_tx("tx_drain2");
        avl_read_chk("wrap_status", ADDR_STATUS);
        for (int i = 0; i < 20; i++) begin
            rx_push(32'h3000 + i);
            avl_read_chk("rx_wrap", ADDR_DATA);
        end

        // RX flush against a same-cycle stream push
        avl_write(ADDR_DATA, 32'h4000);
        avl_write(ADDR_DATA, 32'h4001);
        for (int i = 0; i < 5; i++) rx_push(32'h5000 + i);
        avl_read_chk("pre_flush", ADDR_STATUS);
        RX_VALID = 1'b1; RX_DATA = 32'hDEAD;
        avl_write(ADDR_CONTROL, 32'd6);
        RX_VALID = 1'b0;
        avl_read_chk("post_flush", ADDR_STATUS);
        check_val("flush_rx_empty", rdata & 32'h0008FF00, 32'h00080000);
        check_val("flush_tx_cnt", rdata & 32'hFF, 32'd2);
        drain_tx("tx_drain3");

        // Reset in the middle of traffic
        avl_write(ADDR_DATA, 32'h6000);
        avl_write(ADDR_DATA, 32'h6001);
        rx_push(32'h7000);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        tx_q.delete(); rx_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_irq_en = 1'b0; m_thresh = 5'd1;
        check_val("rst2_tx_valid", {31'b0, TX_VALID}, '0);
        avl_read_chk("rst2_status", ADDR_STATUS);
        check_val("rst2_status_const", rdata, 32'h000A0000);
        avl_read_chk("rst2_thresh", ADDR_THRESH);
        avl_read_chk("rst2_ctrl", ADDR_CONTROL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
